// File: rtl/t03_sprite_layer_if.sv
// rtl/t03_sprite_layer_if.sv - sprite bitmap write port (valid/ready)
interface t03_sprite_layer_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [1:0] wr_sprite;
   logic [8:0] wr_addr;
   logic [7:0] wr_data;

   modport master (
      output wr_valid, wr_sprite, wr_addr, wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid, wr_sprite, wr_addr, wr_data,
      output wr_ready
   );
endinterface

// File: rtl/t03_sprite_layer.sv
// rtl/t03_sprite_layer.sv - multi-sprite VGA overlay, 3-cycle priority-resolved colour
// Optional horizontal mirroring: define T03_SPRITE_FLIP_EN.
module t03_sprite_layer #(
   parameter int NUM_SPR  = 2,
   parameter int SPR_W    = 15,
   parameter int SPR_H    = 20,
   parameter int SCALE_X  = 1,
   parameter int SCALE_Y  = 5,
   parameter int V_ACTIVE = 480
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [10:0]            hcnt_i,
   input  logic [10:0]            vcnt_i,
   input  logic                   frame_start_i,
   input  logic [11*NUM_SPR-1:0]  pos_x_i,
   input  logic [11*NUM_SPR-1:0]  pos_y_i,
   input  logic [NUM_SPR-1:0]     enable_i,
   input  logic [8*NUM_SPR-1:0]   swap_from_i,
   input  logic [8*NUM_SPR-1:0]   swap_to_i,
   input  logic [NUM_SPR-1:0]     flip_x_i,
   t03_sprite_layer_if.slave      wr_if,
   output logic [7:0]             color_o,
   output logic [NUM_SPR-1:0]     hit_vec_o,
   output logic                   any_hit_o
);

   localparam int         DEPTH   = SPR_W * SPR_H;
   localparam logic [11:0] EXT_X  = 12'(SPR_W * SCALE_X);
   localparam logic [11:0] EXT_Y  = 12'(SPR_H * SCALE_Y);

   logic                 wr_ready_q;
   logic                 wr_en;
   logic                 v1_q, v2_q;
   logic [NUM_SPR-1:0]   opaque;
   logic [7:0]           pcol [NUM_SPR];
   logic [7:0]           color_d, color_q;
   logic [NUM_SPR-1:0]   hit_vec_q;
   logic                 any_hit_q;

   // Out-of-range sprite or address is still accepted, it simply writes nothing.
   assign wr_en = wr_if.wr_valid && wr_ready_q
               && ({1'b0, wr_if.wr_sprite} < 3'(NUM_SPR))
               && ({1'b0, wr_if.wr_addr} < 10'(DEPTH));
   assign wr_if.wr_ready = wr_ready_q;

`ifndef T03_SPRITE_FLIP_EN
   logic unused_flip;
   assign unused_flip = ^flip_x_i;
`endif

   for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
      logic [10:0] sx_q, sy_q;
      logic        en_q;
      logic [7:0]  sf_q, st_q;
      logic [11:0] dx, dy, col, row, col_f;
      logic        hit_d, hit1_q, hit2_q;
      logic [8:0]  addr_d, addr1_q;
      logic [7:0]  texel_q;
      logic [7:0]  mem_q [DEPTH];
`ifdef T03_SPRITE_FLIP_EN
      logic        fl_q;
`endif

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sx_q <= '0;
            sy_q <= '0;
            en_q <= 1'b0;
            sf_q <= '0;
            st_q <= '0;
`ifdef T03_SPRITE_FLIP_EN
            fl_q <= 1'b0;
`endif
         end else if (frame_start_i) begin
            sx_q <= pos_x_i[11*i +: 11];
            sy_q <= pos_y_i[11*i +: 11];
            en_q <= enable_i[i];
            sf_q <= swap_from_i[8*i +: 8];
            st_q <= swap_to_i[8*i +: 8];
`ifdef T03_SPRITE_FLIP_EN
            fl_q <= flip_x_i[i];
`endif
         end
      end

      // 12-bit compare keeps x + extent from wrapping near the right/bottom edge.
      always_comb begin
         dx    = {1'b0, hcnt_i} - {1'b0, sx_q};
         dy    = {1'b0, vcnt_i} - {1'b0, sy_q};
         hit_d = en_q
              && ({1'b0, hcnt_i} >= {1'b0, sx_q})
              && ({1'b0, hcnt_i} <  {1'b0, sx_q} + EXT_X)
              && ({1'b0, vcnt_i} >= {1'b0, sy_q})
              && ({1'b0, vcnt_i} <  {1'b0, sy_q} + EXT_Y);
         col   = dx / 12'(SCALE_X);
         row   = dy / 12'(SCALE_Y);
`ifdef T03_SPRITE_FLIP_EN
         col_f = fl_q ? (12'(SPR_W - 1) - col) : col;
`else
         col_f = col;
`endif
         addr_d = hit_d ? 9'(row * 12'(SPR_W) + col_f) : '0;
      end

      always_ff @(posedge clk) begin
         if (wr_en && (wr_if.wr_sprite == 2'(i)))
            mem_q[wr_if.wr_addr] <= wr_if.wr_data;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            hit1_q  <= 1'b0;
            addr1_q <= '0;
            hit2_q  <= 1'b0;
            texel_q <= '0;
         end else begin
            hit1_q  <= hit_d;
            addr1_q <= addr_d;
            hit2_q  <= hit1_q;
            texel_q <= mem_q[addr1_q];
         end
      end

      assign opaque[i] = hit2_q && (texel_q != 8'h00);
      assign pcol[i]   = ((sf_q != 8'h00) && (texel_q == sf_q)) ? st_q : texel_q;
   end

   always_comb begin
      color_d = 8'h00;
      for (int i = NUM_SPR - 1; i >= 0; i--) begin
         if (opaque[i]) color_d = pcol[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ready_q <= 1'b0;
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         color_q    <= '0;
         hit_vec_q  <= '0;
         any_hit_q  <= 1'b0;
      end else begin
         wr_ready_q <= (vcnt_i >= 11'(V_ACTIVE));
         v1_q       <= 1'b1;
         v2_q       <= v1_q;
         color_q    <= v2_q ? color_d : 8'h00;
         hit_vec_q  <= v2_q ? opaque : '0;
         any_hit_q  <= v2_q && (|opaque);
      end
   end

   assign color_o   = color_q;
   assign hit_vec_o = hit_vec_q;
   assign any_hit_o = any_hit_q;

endmodule
